pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter SEG, default 16, carry-lookahead segment width; one pipeline stage per segment.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands and mode valid this cycle.
REQ-006 in_ready  output  1  block accepts a transaction this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; ignored when op_sub=1.
REQ-010 op_sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
REQ-011 out_valid  output  1  result fields valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry-out of the MSB; for op_sub, 1 means no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-016 NSEG = WIDTH/SEG; WIDTH not a multiple of SEG, or SEG > WIDTH, is an elaboration error.
REQ-017 Stage k (0..NSEG-1) computes segment k with an SEG-bit lookahead adder using the carry registered by stage k-1; stage 0 uses cin, or 1 when op_sub=1.
REQ-018 Operand segments above stage k are delay-registered so each segment reaches its adder in the same cycle as its incoming carry; sum segments below stage k are delay-registered to align at the output.
REQ-019 Latency is exactly NSEG cycles from the accept edge to out_valid=1 with no stall; throughput is one transaction per cycle.
REQ-020 Transfer on input occurs when in_valid && in_ready; transfer on output occurs when out_valid && out_ready.
REQ-021 Global enable en = !out_valid || out_ready; in_ready = en; when en=0, every stage register, including valid bits, holds.
REQ-022 When en=1 and in_valid=0, a bubble (valid=0) enters stage 0; bubbles advance like data.
REQ-023 An output transfer and an input transfer in the same cycle are both performed; no transaction is lost or duplicated.
REQ-024 sum/cout/ovf are registered outputs and remain stable while out_valid=1 and out_ready=0.
REQ-025 ovf = carry into MSB XOR carry out of MSB, evaluated on the effective B operand (~B for subtract).
REQ-026 Results are modulo 2^WIDTH; cout is the (WIDTH+1)th bit.
REQ-027 With NSEG=1, the block is a single registered CLA with latency 1.

Reset
REQ-028 rst_n=0 asynchronously clears all valid bits, out_valid, sum, cout and ovf to 0.
REQ-029 In-flight transactions are discarded on reset; no partial result is ever presented.
REQ-030 in_ready is 1 in the first cycle after reset release.

Structure
REQ-031 Shared package pipelined_cla_pkg holds the default WIDTH/SEG constants and the NSEG derivation function.
REQ-032 Sub-module cla_segment, a combinational SEG-bit lookahead adder (inputs a, b, ci; outputs s, co, c_msb), is instantiated once per stage.
REQ-033 No latches; no combinational path from a/b to sum.

Verification
REQ-034 WIDTH=32, SEG=16: a=0x0000FFFF, b=0x00000001, cin=0, add -> after 2 cycles sum=0x00010000, cout=0, ovf=0 (carry crosses the stage boundary).
REQ-035 a=0x7FFFFFFF, b=0x00000001, add -> sum=0x80000000, cout=0, ovf=1; a=0xFFFFFFFF, b=0x00000001, cin=1 -> sum=0x00000001, cout=1, ovf=0.
REQ-036 op_sub: a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-037 Stream of 8 back-to-back transactions, out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 8 results in order with none dropped or duplicated.
REQ-038 Assert rst_n=0 with 2 transactions in flight -> out_valid=0 immediately; nothing emitted after release until new input; then latency of 2 cycles.
REQ-039 Random regression at WIDTH=64/SEG=16 (latency 4) and WIDTH=8/SEG=8 (latency 1) against a reference model, including random out_ready.

Source files
------------

// File: rtl/pipelined_cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder family.
// Holds the default operand/segment widths and the stage-count derivation.
package pipelined_cla_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SEG   = 16;

    function automatic int nseg_f(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead adder built on a parallel-prefix
// generate/propagate tree; c_msb is the carry into the top bit (for overflow).
module cla_segment #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG-1:0] p_s;
    logic [SEG-1:0] g_lvl_s;
    logic [SEG-1:0] p_lvl_s;
    logic [SEG-1:0] g_nxt_s;
    logic [SEG-1:0] p_nxt_s;
    logic [SEG:0]   c_s;

    // Prefix tree: after the last level g_lvl_s[i]/p_lvl_s[i] span bits i..0.
    always_comb begin
        p_s     = a ^ b;
        g_lvl_s = a & b;
        p_lvl_s = p_s;
        g_nxt_s = g_lvl_s;
        p_nxt_s = p_lvl_s;
        for (int d = 1; d < SEG; d = d * 2) begin
            g_nxt_s = g_lvl_s;
            p_nxt_s = p_lvl_s;
            for (int i = d; i < SEG; i++) begin
                g_nxt_s[i] = g_lvl_s[i] | (p_lvl_s[i] & g_lvl_s[i-d]);
                p_nxt_s[i] = p_lvl_s[i] & p_lvl_s[i-d];
            end
            g_lvl_s = g_nxt_s;
            p_lvl_s = p_nxt_s;
        end
        c_s    = '0;
        c_s[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            c_s[i+1] = g_lvl_s[i] | (p_lvl_s[i] & ci);
        end
    end

    assign s     = p_s ^ c_s[SEG-1:0];
    assign co    = c_s[SEG];
    assign c_msb = c_s[SEG-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Segmented, pipelined carry-lookahead adder/subtractor with valid/ready
// handshake; one pipeline stage per SEG-bit segment, latency NSEG.
module pipelined_cla_adder
    import pipelined_cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG   = DEFAULT_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = nseg_f(WIDTH, SEG);

    if ((SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of SEG");
    end

    logic                       en_s;
    logic [NSEG-1:0]            valid_r;
    logic [NSEG-1:0]            carry_r;
    logic [NSEG-1:0][WIDTH-1:0] a_r;
    logic [NSEG-1:0][WIDTH-1:0] b_r;
    logic [NSEG-1:0][WIDTH-1:0] sum_r;
    logic                       ovf_r;

    logic [NSEG-1:0]            vin_s;
    logic [NSEG-1:0]            cin_stage_s;
    logic [NSEG-1:0][WIDTH-1:0] ain_s;
    logic [NSEG-1:0][WIDTH-1:0] bin_s;
    logic [NSEG-1:0][WIDTH-1:0] sin_s;
    logic [NSEG-1:0][WIDTH-1:0] snext_s;
    logic [NSEG-1:0][SEG-1:0]   seg_sum_s;
    logic [NSEG-1:0]            seg_co_s;
    logic [NSEG-1:0]            seg_cmsb_s;
    logic                       unused_tail_s;

    assign en_s = !valid_r[NSEG-1] || out_ready;

    // Stage k consumes stage k-1's registers; stage 0 takes the ports (B inverted for subtract).
    always_comb begin
        vin_s[0]       = in_valid;
        ain_s[0]       = a;
        bin_s[0]       = op_sub ? ~b : b;
        sin_s[0]       = '0;
        cin_stage_s[0] = op_sub ? 1'b1 : cin;
        for (int k = 1; k < NSEG; k++) begin
            vin_s[k]       = valid_r[k-1];
            ain_s[k]       = a_r[k-1];
            bin_s[k]       = b_r[k-1];
            sin_s[k]       = sum_r[k-1];
            cin_stage_s[k] = carry_r[k-1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        cla_segment #(.SEG(SEG)) u_seg (
            .a     (ain_s[k][k*SEG +: SEG]),
            .b     (bin_s[k][k*SEG +: SEG]),
            .ci    (cin_stage_s[k]),
            .s     (seg_sum_s[k]),
            .co    (seg_co_s[k]),
            .c_msb (seg_cmsb_s[k])
        );
    end

    // Merge each stage's freshly computed segment into its partial sum.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            snext_s[k]                 = sin_s[k];
            snext_s[k][k*SEG +: SEG]   = seg_sum_s[k];
        end
    end

    // Pipeline registers: the whole pipe advances only when the output slot frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            carry_r <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            ovf_r   <= 1'b0;
        end else if (en_s) begin
            valid_r <= vin_s;
            carry_r <= seg_co_s;
            a_r     <= ain_s;
            b_r     <= bin_s;
            sum_r   <= snext_s;
            ovf_r   <= seg_co_s[NSEG-1] ^ seg_cmsb_s[NSEG-1];
        end
    end

    // Operands reaching the last stage have been fully consumed.
    assign unused_tail_s = ^{a_r[NSEG-1], b_r[NSEG-1]};

    assign in_ready  = en_s;
    assign out_valid = valid_r[NSEG-1];
    assign sum       = sum_r[NSEG-1];
    assign cout      = carry_r[NSEG-1];
    assign ovf       = ovf_r;

endmodule
